ofdm_tx_framer: RTL and testbench

OFDM_TX_FRAMER -- requirements
Module: ofdm_tx_framer

---
 rtl/ofdm_tx_framer.sv | 158 +++++++++++++++
 tb/tb_ofdm_tx_framer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_tx_framer.sv
// rtl/ofdm_tx_framer.sv - Gray-QPSK mapper with ping-pong symbol banks and cyclic-prefix framing.
module ofdm_tx_framer #(
    parameter int sample_bit_width_g  = 12,
    parameter int symbol_length_g     = 160,
    parameter int raw_symbol_length_g = 128,
    parameter int strobe_period_g     = 24,
    parameter int qpsk_amplitude_g    = 1024
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic                          sys_init,
    input  logic [1:0]                    tx_data,
    input  logic                          tx_data_valid,
    input  logic                          tx_data_start,
    output logic                          tx_data_ready,
    output logic [sample_bit_width_g-1:0] tx_out_i,
    output logic [sample_bit_width_g-1:0] tx_out_q,
    output logic                          tx_out_valid,
    output logic                          tx_out_start
);

    localparam int CP_LEN = symbol_length_g - raw_symbol_length_g;
    localparam int IDX_W  = $clog2(raw_symbol_length_g);
    localparam int CNT_W  = $clog2(strobe_period_g + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(raw_symbol_length_g - 1);
    localparam logic [IDX_W-1:0] CP_LAST  = IDX_W'(CP_LEN - 1);
    localparam logic [IDX_W-1:0] CP_BASE  = IDX_W'(raw_symbol_length_g - CP_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(strobe_period_g);
    localparam logic [sample_bit_width_g-1:0] POS = sample_bit_width_g'(qpsk_amplitude_g);
    localparam logic [sample_bit_width_g-1:0] NEG = sample_bit_width_g'(-qpsk_amplitude_g);

    typedef enum logic [1:0] {IDLE, SEND_CP, SEND_DATA} state_t;

    // Banks hold raw bit pairs; the constellation is applied on the way out.
    logic [1:0] bank_mem [2][raw_symbol_length_g];

    state_t                          state_q;
    logic [IDX_W-1:0]                n_q;
    logic [IDX_W-1:0]                k_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            wr_bank_q;
    logic                            rd_bank_q;
    logic [1:0]                      full_q;
    logic [1:0]                      full_d;
    logic [sample_bit_width_g-1:0]   out_i_q;
    logic [sample_bit_width_g-1:0]   out_q_q;
    logic                            out_valid_q;
    logic                            out_start_q;

    logic             strobe;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_last;
    logic             emit;
    logic             release_bank;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_pair;

    assign strobe       = (cnt_q == CNT_MAX);
    assign wr_en        = tx_data_valid && !full_q[wr_bank_q];
    assign wr_idx       = tx_data_start ? '0 : k_q;
    assign wr_last      = wr_en && (wr_idx == LAST_IDX);
    assign emit         = strobe && (state_q != IDLE);
    assign release_bank = strobe && (state_q == SEND_DATA) && (n_q == LAST_IDX);
    assign rd_idx       = (state_q == SEND_CP) ? CP_BASE + n_q : n_q;
    assign rd_pair      = bank_mem[rd_bank_q][rd_idx];

    // Write completion and read release touch different banks, so both apply.
    always_comb begin
        full_d = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) bank_mem[wr_bank_q][wr_idx] <= tx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
        end else if (sys_init) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
        end else begin
            cnt_q  <= strobe ? CNT_W'(1) : cnt_q + 1'b1;
            full_q <= full_d;
            if (wr_en) begin
                if (wr_last) begin
                    wr_bank_q <= ~wr_bank_q;
                    k_q       <= '0;
                end else begin
                    k_q <= wr_idx + 1'b1;
                end
            end
            out_valid_q <= emit;
            out_start_q <= emit && (state_q == SEND_CP) && (n_q == '0);
            if (emit) begin
                out_i_q <= rd_pair[1] ? NEG : POS;
                out_q_q <= rd_pair[0] ? NEG : POS;
            end
            if (strobe) begin
                case (state_q)
                    IDLE: begin
                        if (full_q[rd_bank_q]) begin
                            state_q <= SEND_CP;
                            n_q     <= '0;
                        end
                    end
                    SEND_CP: begin
                        if (n_q == CP_LAST) begin
                            state_q <= SEND_DATA;
                            n_q     <= '0;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                    SEND_DATA: begin
                        if (n_q == LAST_IDX) begin
                            rd_bank_q <= ~rd_bank_q;
                            n_q       <= '0;
                            state_q   <= full_q[~rd_bank_q] ? SEND_CP : IDLE;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_data_ready = !full_q[wr_bank_q];
    assign tx_out_i      = out_i_q;
    assign tx_out_q      = out_q_q;
    assign tx_out_valid  = out_valid_q;
    assign tx_out_start  = out_start_q;

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// tb/tb_ofdm_tx_framer.sv - self-checking bench for ofdm_tx_framer against a queue-based symbol model.
module tb_ofdm_tx_framer;

    localparam int W   = 12;
    localparam int SYM = 160;
    localparam int RAW = 128;
    localparam int P   = 24;
    localparam int A   = 1024;
    localparam int L   = SYM - RAW;

    logic         sys_clk = 1'b0;
    logic         sys_rstn = 1'b0;
    logic         sys_init = 1'b0;
    logic [1:0]   tx_data = 2'b00;
    logic         tx_data_valid = 1'b0;
    logic         tx_data_start = 1'b0;
    logic         tx_data_ready;
    logic [W-1:0] tx_out_i;
    logic [W-1:0] tx_out_q;
    logic         tx_out_valid;
    logic         tx_out_start;

    ofdm_tx_framer #(
        .sample_bit_width_g (W),
        .symbol_length_g    (SYM),
        .raw_symbol_length_g(RAW),
        .strobe_period_g    (P),
        .qpsk_amplitude_g   (A)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rstn     (sys_rstn),
        .sys_init     (sys_init),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_start(tx_data_start),
        .tx_data_ready(tx_data_ready),
        .tx_out_i     (tx_out_i),
        .tx_out_q     (tx_out_q),
        .tx_out_valid (tx_out_valid),
        .tx_out_start (tx_out_start)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {int i; int q; bit st;} samp_t;
    typedef struct {int cyc; int i; int q; bit st;} lg_t;

    // Model: two banks of mapped samples plus a queue of the symbol currently being sent.
    samp_t pend[$];
    lg_t   log_q[$];
    int    m_cnt, m_wr, m_rd, m_k;
    bit    m_full[2];
    int    bi[2][RAW];
    int    bq[2][RAW];
    int    e_i, e_q;
    bit    e_v, e_s;
    int    cyc = 0;
    int    rec_i[RAW];
    int    rec_q[RAW];

    function automatic int amp(input bit b);
        return b ? -A : A;
    endfunction

    function automatic void m_reset();
        pend.delete();
        m_cnt = 0; m_wr = 0; m_rd = 0; m_k = 0;
        m_full[0] = 0; m_full[1] = 0;
        e_i = 0; e_q = 0; e_v = 0; e_s = 0;
    endfunction

    function automatic void build(input int b);
        for (int n = 0; n < L; n++) pend.push_back('{bi[b][RAW-L+n], bq[b][RAW-L+n], n == 0});
        for (int n = 0; n < RAW; n++) pend.push_back('{bi[b][n], bq[b][n], 1'b0});
    endfunction

    function automatic void m_step();
        bit    strobe;
        bit    fp[2];
        samp_t s;
        int    idx;
        strobe = (m_cnt == P);
        fp = m_full;
        e_v = 0;
        e_s = 0;
        if (strobe) begin
            if (pend.size() == 0) begin
                if (fp[m_rd]) build(m_rd);
            end else begin
                s = pend.pop_front();
                e_v = 1; e_s = s.st; e_i = s.i; e_q = s.q;
                if (pend.size() == 0) begin
                    m_full[m_rd] = 0;
                    m_rd ^= 1;
                    if (fp[m_rd]) build(m_rd);
                end
            end
        end
        if (tx_data_valid && !fp[m_wr]) begin
            idx = tx_data_start ? 0 : m_k;
            bi[m_wr][idx] = amp(tx_data[1]);
            bq[m_wr][idx] = amp(tx_data[0]);
            if (idx == RAW - 1) begin
                m_full[m_wr] = 1;
                m_wr ^= 1;
                m_k = 0;
            end else begin
                m_k = idx + 1;
            end
        end
        m_cnt = strobe ? 1 : m_cnt + 1;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rstn);
            if (!sys_rstn || sys_init) m_reset();
            else m_step();
        end
    end

    always @(negedge sys_clk) begin
        cyc++;
        check("ready", int'(tx_data_ready), int'(!m_full[m_wr]));
        check("out_valid", int'(tx_out_valid), int'(e_v));
        check("out_start", int'(tx_out_start), int'(e_s));
        check("out_i", int'($signed(tx_out_i)), e_i);
        check("out_q", int'($signed(tx_out_q)), e_q);
        if (tx_out_valid) log_q.push_back('{cyc, int'($signed(tx_out_i)), int'($signed(tx_out_q)), tx_out_start});
    end

    task automatic send_pair(input logic [1:0] d, input bit s);
        int t = 0;
        tx_data = d; tx_data_start = s; tx_data_valid = 1'b1;
        while (!tx_data_ready && t < 10000) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 10000) check("ready_timeout", 0, 1);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        tx_data_valid = 1'b0; tx_data_start = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int t = 0;
        while (log_q.size() < n && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        if (log_q.size() < n) check("pulse_timeout", log_q.size(), n);
    endtask

    task automatic send_rand_sym(input bit st);
        logic [1:0] d;
        for (int p = 0; p < RAW; p++) begin
            d = 2'($urandom_range(3));
            rec_i[p] = amp(d[1]); rec_q[p] = amp(d[0]);
            send_pair(d, st && p == 0);
        end
    endtask

    // Checks one logged symbol against rec_i/rec_q: CP is the tail of the data.
    task automatic check_sym(input string tag);
        int bad = 0, starts = 0, gaps = 0, first_st = 0, n;
        check({tag, "_count"}, log_q.size(), SYM);
        n = (log_q.size() < SYM) ? log_q.size() : SYM;
        for (int k = 0; k < n; k++) begin
            int e = (k < L) ? RAW - L + k : k - L;
            if (log_q[k].i != rec_i[e] || log_q[k].q != rec_q[e]) bad++;
            if (log_q[k].st) starts++;
            if (k > 0 && log_q[k].cyc - log_q[k-1].cyc != P) gaps++;
        end
        if (n > 0) first_st = int'(log_q[0].st);
        check({tag, "_values"}, bad, 0);
        check({tag, "_starts"}, starts, 1);
        check({tag, "_first_start"}, first_st, 1);
        check({tag, "_spacing"}, gaps, 0);
    endtask

    initial begin
        int st_cyc[$];
        logic [1:0] d;

        repeat (3) @(negedge sys_clk);
        check("reset_ready", int'(tx_data_ready), 1);
        check("reset_valid", int'(tx_out_valid), 0);
        check("reset_i", int'(tx_out_i), 0);
        sys_rstn = 1'b1;
        idle(5);

        // All-zero symbol: every sample +A.
        log_q.delete();
        for (int p = 0; p < RAW; p++) begin
            rec_i[p] = A; rec_q[p] = A;
            send_pair(2'b00, p == 0);
        end
        idle(1);
        wait_pulses(SYM, 6000);
        idle(200);
        check_sym("zeros");
        if (log_q.size() > 0) check("zeros_first_i", log_q[0].i, 1024);

        // Pair index mod 4.
        log_q.delete();
        for (int p = 0; p < RAW; p++) begin
            d = 2'(p % 4);
            rec_i[p] = amp(d[1]); rec_q[p] = amp(d[0]);
            send_pair(d, p == 0);
        end
        idle(1);
        wait_pulses(SYM, 6000);
        idle(200);
        check_sym("mod4");
        if (log_q.size() >= 36) begin
            check("mod4_cp0_i", log_q[0].i, 1024);
            check("mod4_cp0_q", log_q[0].q, 1024);
            check("mod4_cp1_q", log_q[1].q, -1024);
            check("mod4_s32_i", log_q[32].i, 1024);
            check("mod4_s34_i", log_q[34].i, -1024);
            check("mod4_s34_q", log_q[34].q, 1024);
            check("mod4_s35_i", log_q[35].i, -1024);
            check("mod4_s35_q", log_q[35].q, -1024);
        end

        // Three symbols back to back.
        log_q.delete();
        for (int p = 0; p < 3 * RAW; p++) begin
            send_pair(2'($urandom_range(3)), p % RAW == 0);
            if (p == 2 * RAW - 1) check("b2b_ready_low", int'(tx_data_ready), 0);
        end
        idle(1);
        wait_pulses(3 * SYM, 15000);
        idle(200);
        foreach (log_q[k]) if (log_q[k].st) st_cyc.push_back(log_q[k].cyc);
        check("b2b_starts", st_cyc.size(), 3);
        if (st_cyc.size() == 3) begin
            check("b2b_gap1", st_cyc[1] - st_cyc[0], SYM * P);
            check("b2b_gap2", st_cyc[2] - st_cyc[1], SYM * P);
        end

        // Partial symbol abandoned by a new start.
        log_q.delete();
        for (int p = 0; p < 50; p++) send_pair(2'($urandom_range(3)), p == 0);
        send_rand_sym(1'b1);
        idle(1);
        wait_pulses(SYM, 6000);
        idle(4000);
        check_sym("restart");

        // Reset in the middle of a symbol.
        log_q.delete();
        send_rand_sym(1'b1);
        idle(1);
        wait_pulses(70, 6000);
        @(negedge sys_clk);
        #2 sys_rstn = 1'b0;
        #1;
        check("rst_ready", int'(tx_data_ready), 1);
        check("rst_valid", int'(tx_out_valid), 0);
        check("rst_start", int'(tx_out_start), 0);
        check("rst_i", int'(tx_out_i), 0);
        check("rst_q", int'(tx_out_q), 0);
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;
        idle(2);
        log_q.delete();
        send_rand_sym(1'b1);
        idle(1);
        wait_pulses(SYM, 6000);
        idle(200);
        check_sym("after_rst");

        // Synchronous init mid-write.
        log_q.delete();
        for (int p = 0; p < 60; p++) send_pair(2'($urandom_range(3)), p == 0);
        tx_data_valid = 1'b0;
        sys_init = 1'b1;
        @(negedge sys_clk);
        sys_init = 1'b0;
        check("init_ready", int'(tx_data_ready), 1);
        send_rand_sym(1'b0);
        idle(1);
        wait_pulses(SYM, 6000);
        idle(200);
        check_sym("after_init");

        // Randomized traffic with occasional starts and inits.
        for (int it = 0; it < 500; it++) begin
            int r = int'($urandom_range(99));
            if (r < 2) begin
                tx_data_valid = 1'b0;
                sys_init = 1'b1;
                @(negedge sys_clk);
                sys_init = 1'b0;
            end else if (r < 30) begin
                idle(1);
            end else begin
                send_pair(2'($urandom_range(3)), $urandom_range(39) == 0);
            end
        end
        idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
